commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Sits directly downstream of the core's retirement outputs and consumes one commit record per retired instruction. Each record holds pc, instr, rd, rd data and mem addr/data. The block classifies the record by opcode and buffers it in a FIFO. It then presents the records on a valid/ready stream to a trace sink (UART/debug bridge), so the commit log can be produced in hardware rather than by bench probing. It also counts retired instructions and dropped records.

Parameters:
XLEN, 32, datapath width (riscv_pkg::XLEN)
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 16, width of drop counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  capture enable; when 0, commits are not pushed or counted
commit_valid_i  in  1  one instruction retires this cycle
commit_pc_i  in  XLEN  pc of retired instruction
commit_instr_i  in  32  instruction word
commit_rd_i  in  5  destination register
commit_rd_data_i  in  XLEN  value written to rd
commit_mem_addr_i  in  XLEN  load/store effective address
commit_mem_data_i  in  XLEN  store data
trc_valid_o  out  1  record available
trc_ready_i  in  1  sink accepts record
trc_o  out  trace_rec_t  packed record {kind, pc, instr, rd, data, addr}
retired_o  out  XLEN  retired-instruction counter
drop_cnt_o  out  CNT_W  records lost to overflow
overflow_o  out  1  sticky: at least one record dropped
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: FIFO empty, trc_valid_o=0, trc_o=0, retired_o=0, drop_cnt_o=0, overflow_o=0, level_o=0.
- Reset mid-stream: all entries are discarded, with no partial record.
- Push condition: push = commit_valid_i & enable_i.
- Classification uses opcode commit_instr_i[6:0] (custom_pkg OP_*):
  - OP_BRANCH: kind=TR_PLAIN; rd, data and addr forced to 0.
  - OP_STORE: kind=TR_STORE; rd=0; addr=mem_addr; data=mem_data.
  - OP_LOAD: kind=TR_LOAD if rd!=0, else TR_PLAIN; addr=mem_addr; data=rd_data.
  - All others: kind=TR_REG if rd!=0, else TR_PLAIN; data=rd_data; addr=0.
  - TR_PLAIN records have rd, data and addr all zero.
- Latency: a record pushed in cycle N is visible at trc_o with trc_valid_o=1 in cycle N+1 when the FIFO was empty. There is no combinational path from commit_* to trc_*.
- Handshake:
  - Pop = trc_valid_o & trc_ready_i.
  - trc_o stays stable while trc_valid_o=1 and trc_ready_i=0.
  - trc_valid_o never drops without a pop, except on reset.
- Ordering: strict FIFO order.
- Pointers: read and write pointers have log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full = MSB differs and the rest are equal; empty = pointers equal.
- Full FIFO:
  - Push without pop drops the new record, increments drop_cnt_o (saturating at all-ones) and sets overflow_o (cleared only by reset).
  - Push with simultaneous pop is accepted: no drop, level unchanged.
- Empty FIFO: trc_ready_i is ignored and level_o stays 0.
- Simultaneous push and pop when not empty: level unchanged.
- retired_o increments by 1 on every push, including dropped ones. It wraps modulo 2^XLEN.
- level_o = write pointer − read pointer; range 0..DEPTH.

Decomposition:
- custom_pkg:
  - trace_kind_e (2-bit enum: TR_PLAIN, TR_REG, TR_LOAD, TR_STORE).
  - trace_rec_t packed struct.
  - Reuses the existing OP_* opcode constants.
- Sub-module sync_fifo: parameterized by element type/width and DEPTH, exposing push, pop, full, empty and level.
- Classification and counters stay in the top.

Test Plan:
- Reset, then commit instr 0x00500093 (addi x1,x0,5) at pc 0x0, rd=1, rd_data=5, ready=1 -> next cycle trc_valid_o=1, kind=TR_REG, rd=1, data=0x5; retired_o=1.
- Store 0x00112023 with addr 0x100, mem_data 0xDEADBEEF -> kind=TR_STORE, rd=0, addr=0x100, data=0xDEADBEEF. Branch 0x00208463 -> kind=TR_PLAIN, all fields except pc/instr zero.
- ready=0 with 10 consecutive commits, DEPTH=8 -> level_o=8, drop_cnt_o=2, overflow_o=1, retired_o=10. Draining yields the first 8 pcs in order.
- FIFO full with push and pop in the same cycle -> drop_cnt_o unchanged, level_o stays 8, popped record is the oldest.
- enable_i=0 with 3 commits -> no records, retired_o unchanged. Assert rst_i with 5 entries queued -> next cycle level_o=0, trc_valid_o=0, counters 0.
- ready toggled randomly over 100 commits with no overflow -> output sequence equals input sequence; trc_o stable while stalled.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace path: opcodes, record kinds and
// the packed trace record handed to the sink.
package commit_trace_buffer_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    TR_PLAIN = 2'd0,
    TR_REG   = 2'd1,
    TR_LOAD  = 2'd2,
    TR_STORE = 2'd3
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e       kind;
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic [4:0]        rd;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   addr;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  function automatic logic [6:0] opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/commit_trace_buffer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is zero while
// empty so the consumer never sees stale entries.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A full FIFO still takes a write when the head leaves this cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Classifies retired instructions into trace records, queues them
// for a valid/ready sink and counts retirements and drops.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int XLEN  = commit_trace_buffer_pkg::XLEN,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     commit_valid_i,
  input  logic [XLEN-1:0]          commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic [4:0]               commit_rd_i,
  input  logic [XLEN-1:0]          commit_rd_data_i,
  input  logic [XLEN-1:0]          commit_mem_addr_i,
  input  logic [XLEN-1:0]          commit_mem_data_i,
  output logic                     trc_valid_o,
  input  logic                     trc_ready_i,
  output trace_rec_t               trc_o,
  output logic [XLEN-1:0]          retired_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  trace_rec_t rec;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;
  logic       is_ld;
  logic       is_st;
  logic       is_br;
  logic       rd_nz;
  logic [REC_W-1:0] rdata;

  assign is_ld = (opcode(commit_instr_i) == OP_LOAD);
  assign is_st = (opcode(commit_instr_i) == OP_STORE);
  assign is_br = (opcode(commit_instr_i) == OP_BRANCH);
  assign rd_nz = (commit_rd_i != 5'd0);

  always_comb begin
    rec       = '0;
    rec.kind  = TR_PLAIN;
    rec.pc    = commit_pc_i;
    rec.instr = commit_instr_i;
    unique case (1'b1)
      is_br: ;
      is_st: begin
        rec.kind = TR_STORE;
        rec.data = commit_mem_data_i;
        rec.addr = commit_mem_addr_i;
      end
      is_ld: begin
        if (rd_nz) begin
          rec.kind = TR_LOAD;
          rec.rd   = commit_rd_i;
          rec.data = commit_rd_data_i;
          rec.addr = commit_mem_addr_i;
        end
      end
      default: begin
        if (rd_nz) begin
          rec.kind = TR_REG;
          rec.rd   = commit_rd_i;
          rec.data = commit_rd_data_i;
        end
      end
    endcase
  end

  assign push = commit_valid_i & enable_i;
  assign pop  = trc_valid_o & trc_ready_i;
  assign drop = push & full & ~pop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  assign trc_valid_o = ~empty;
  assign trc_o       = trace_rec_t'(rdata);

  // Dropped records still count as retired.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) retired_o <= retired_o + XLEN'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: classification, overflow,
// full push/pop, enable, reset and a randomly stalled stream.
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        cvalid = 1'b0;
  logic [31:0] cpc = '0;
  logic [31:0] cinstr = '0;
  logic [4:0]  crd = '0;
  logic [31:0] crdd = '0;
  logic [31:0] cmaddr = '0;
  logic [31:0] cmdata = '0;
  logic        tvalid;
  logic        tready = 1'b1;
  trace_rec_t  trc;
  logic [31:0] retired;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .XLEN(32), .DEPTH(8), .CNT_W(16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .commit_valid_i    (cvalid),
    .commit_pc_i       (cpc),
    .commit_instr_i    (cinstr),
    .commit_rd_i       (crd),
    .commit_rd_data_i  (crdd),
    .commit_mem_addr_i (cmaddr),
    .commit_mem_data_i (cmdata),
    .trc_valid_o       (tvalid),
    .trc_ready_i       (tready),
    .trc_o             (trc),
    .retired_o         (retired),
    .drop_cnt_o        (drop_cnt),
    .overflow_o        (overflow),
    .level_o           (level)
  );

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rd, input logic [31:0] rdd,
                        input logic [31:0] maddr, input logic [31:0] mdata);
    cvalid = 1'b1;
    cpc = pc; cinstr = instr; crd = rd;
    crdd = rdd; cmaddr = maddr; cmdata = mdata;
    if (enable) exp_ret++;
    @(negedge clk);
    cvalid = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] kind,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic [31:0] data,
                         input logic [31:0] addr);
    trace_rec_t e;
    e.kind = trace_kind_e'(kind);
    e.pc = pc; e.instr = instr; e.rd = rd;
    e.data = data; e.addr = addr;
    chk(tag, trc, e);
  endtask

  initial begin
    trace_rec_t q[$];
    trace_rec_t r;
    trace_rec_t held;
    logic held_v;
    int sent;
    int got;

    repeat (2) @(negedge clk);
    chk("rst_valid", tvalid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_retired", retired, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_trc", trc, 0);
    rst = 1'b0;

    commit(32'h0, 32'h00500093, 5'd1, 32'h5, 32'h77, 32'h99);
    chk("addi_valid", tvalid, 1'b1);
    chk_rec("addi_rec", 2'd1, 32'h0, 32'h00500093, 5'd1, 32'h5, 32'h0);
    chk("addi_ret", retired, 1);

    commit(32'h4, 32'h00112023, 5'd5, 32'h11, 32'h100, 32'hDEADBEEF);
    chk_rec("st_rec", 2'd3, 32'h4, 32'h00112023, 5'd0,
            32'hDEADBEEF, 32'h100);
    chk("st_level", level, 1);

    commit(32'h8, 32'h00208463, 5'd8, 32'h1234, 32'h55, 32'h66);
    chk_rec("br_rec", 2'd0, 32'h8, 32'h00208463, 5'd0, 32'h0, 32'h0);

    commit(32'hC, 32'h0000a183, 5'd3, 32'hCAFE, 32'h200, 32'h1);
    chk_rec("ld_rec", 2'd2, 32'hC, 32'h0000a183, 5'd3, 32'hCAFE, 32'h200);

    commit(32'h10, 32'h0000a003, 5'd0, 32'hCAFE, 32'h200, 32'h1);
    chk_rec("ld_x0_rec", 2'd0, 32'h10, 32'h0000a003, 5'd0, 32'h0, 32'h0);

    commit(32'h14, 32'h00000013, 5'd0, 32'hBEEF, 32'h300, 32'h2);
    chk_rec("nop_rec", 2'd0, 32'h14, 32'h00000013, 5'd0, 32'h0, 32'h0);
    chk("cls_ret", retired, 6);

    @(negedge clk);
    chk("drain_level", level, 0);

    tready = 1'b0;
    for (int i = 0; i < 10; i++)
      commit(32'h1000 + 32'(4 * i), 32'h00100093, 5'd1, 32'(i), 0, 0);
    chk("ovf_level", level, 8);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_ret", retired, 16);
    chk("ovf_head", trc.pc, 32'h1000);

    tready = 1'b1;
    commit(32'h2000, 32'h00100093, 5'd1, 32'h0, 0, 0);
    chk("fpp_level", level, 8);
    chk("fpp_drop", drop_cnt, 2);
    chk("fpp_ret", retired, exp_ret);
    for (int k = 1; k < 8; k++) begin
      chk("drain_pc", trc.pc, 32'h1000 + 32'(4 * k));
      @(negedge clk);
    end
    chk("drain_last", trc.pc, 32'h2000);
    @(negedge clk);
    chk("empty_valid", tvalid, 1'b0);
    chk("empty_trc", trc, 0);
    @(negedge clk);
    chk("empty_level", level, 0);
    chk("ovf_sticky", overflow, 1'b1);

    enable = 1'b0;
    for (int i = 0; i < 3; i++)
      commit(32'h3000 + 32'(4 * i), 32'h00100093, 5'd1, 0, 0, 0);
    chk("dis_ret", retired, exp_ret);
    chk("dis_valid", tvalid, 1'b0);
    chk("dis_level", level, 0);
    enable = 1'b1;

    tready = 1'b0;
    for (int i = 0; i < 5; i++)
      commit(32'h3100 + 32'(4 * i), 32'h00100093, 5'd1, 0, 0, 0);
    chk("pre_rst_level", level, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    chk("mrst_level", level, 0);
    chk("mrst_valid", tvalid, 1'b0);
    chk("mrst_ret", retired, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_ovf", overflow, 1'b0);

    sent = 0;
    got = 0;
    held_v = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
      chk("rnd_valid", tvalid, q.size() != 0);
      if (q.size() != 0) chk("rnd_rec", trc, q[0]);
      if (held_v) chk("rnd_stable", trc, held);
      tready = ($urandom_range(0, 3) != 0);
      held_v = (q.size() != 0) && !tready;
      held = trc;
      if (q.size() != 0 && tready) begin
        void'(q.pop_front());
        got++;
      end
      if (sent < 100 && q.size() < 6 && $urandom_range(0, 1) == 1) begin
        r.kind = TR_REG;
        r.pc = 32'h4000 + 32'(4 * sent);
        r.instr = 32'h00000113;
        r.rd = 5'd2;
        r.data = r.pc ^ 32'h5a5a;
        r.addr = '0;
        cvalid = 1'b1;
        cpc = r.pc; cinstr = r.instr; crd = r.rd;
        crdd = r.data; cmaddr = $urandom; cmdata = $urandom;
        q.push_back(r);
        sent++;
        exp_ret++;
      end else begin
        cvalid = 1'b0;
      end
      @(negedge clk);
    end
    cvalid = 1'b0;
    chk("rnd_sent", sent, 100);
    chk("rnd_got", got, 100);
    chk("rnd_ret", retired, exp_ret);
    chk("rnd_drop", drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
